axi_log2lin: RTL and testbench



---
 rtl/axi_log2lin_pkg.sv | 20 ++
 rtl/log2lin_rom.sv | 45 ++++
 rtl/axi_log2lin.sv | 145 ++++++++++++++
 tb/tb_axi_log2lin.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/axi_log2lin_pkg.sv
// Shared definitions for the log2-power <-> linear converters.
// The packing helpers live here so the encoder and decoder cannot diverge.
package axi_log2lin_pkg;
  localparam int LOG_INT_BITS  = 5;
  localparam int LOG_FRAC_BITS = 11;
  localparam int LOG_BITS      = LOG_INT_BITS + LOG_FRAC_BITS;
  localparam int MANT_BITS     = 16;
  localparam int MANT_ONE      = 32768;

  typedef logic [LOG_BITS-1:0] log_word_t;

  function automatic logic [31:0] pack_log(input log_word_t l);
    return {1'b0, l[15:1], 16'b0};
  endfunction

  // hi is the upper half of the stream word; the lower half never carries data
  function automatic log_word_t unpack_log(input logic [15:0] hi, input bit packed_fmt);
    return packed_fmt ? {hi[14:0], 1'b0} : hi;
  endfunction
endpackage

// File: rtl/log2lin_rom.sv
// Dual-port mantissa table m[j] = round(32768 * 2^(j/2^LUT_BITS)), j = 0..2^LUT_BITS.
// Both read ports are registered so the table maps onto block or distributed ROM.
module log2lin_rom #(
  parameter int LUT_BITS = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LUT_BITS:0] addr_a,
  input  logic [LUT_BITS:0] addr_b,
  output logic [16:0]       data_a,
  output logic [16:0]       data_b
);
  localparam int DEPTH = (1 << LUT_BITS) + 1;

  function automatic logic [16:0] entry(input int j);
    real x;
    x = 32768.0 * (2.0 ** (real'(j) / real'(1 << LUT_BITS)));
    return 17'($rtoi(x + 0.5));
  endfunction

  logic [16:0] rom [DEPTH];

  for (genvar j = 0; j < DEPTH; j++) begin : g_rom
    assign rom[j] = entry(j);
  end

  logic [16:0] data_a_q, data_a_d, data_b_q, data_b_d;

  always_comb begin
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    if (en) begin
      data_a_d = rom[addr_a];
      data_b_d = rom[addr_b];
    end
  end

  always_ff @(posedge clk) begin
    data_a_q <= data_a_d;
    data_b_q <= data_b_d;
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;
endmodule

// File: rtl/axi_log2lin.sv
// AXI-stream log2-power (Q5.11) to 32-bit linear power, o = 2^(L/2048).
// Four register stages under one global enable; tlast rides with its sample.
module axi_log2lin
  import axi_log2lin_pkg::*;
#(
  parameter int LUT_BITS = 8,
  parameter bit INTERP   = 1'b1,
  parameter bit UNPACK   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready
);
  localparam int RW   = LOG_FRAC_BITS - LUT_BITS;
  localparam int RW_E = (RW > 0) ? RW : 1;

  logic en;
  logic unused_tdata;
  assign unused_tdata = ^{i_tdata[31], i_tdata[15:0]};

  logic            vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  log_word_t       l_p1_q, l_p1_d;
  logic [RW_E-1:0] r_p1;
  logic [LUT_BITS-1:0] k_p1;
  logic [LUT_BITS:0]   addr_lo, addr_hi;

  logic            vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic [4:0]      e_p2_q, e_p2_d;
  logic [RW_E-1:0] r_p2_q, r_p2_d;
  logic [16:0]     m_lo_p2, m_hi_p2;

  logic            vld_p3_q, vld_p3_d, last_p3_q, last_p3_d;
  logic [4:0]      e_p3_q, e_p3_d;
  logic [15:0]     mant_p3_q, mant_p3_d;

  logic            vld_p4_q, vld_p4_d, last_p4_q, last_p4_d;
  logic [31:0]     data_p4_q, data_p4_d;

  function automatic logic [15:0] sat16(input logic [17:0] v);
    return (v > 18'd65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [15:0] form_mant(input logic [16:0] lo, input logic [16:0] hi,
                                            input logic [RW_E-1:0] r);
    logic [16:0]      diff;
    logic [16+RW_E:0] prod;
    logic [17:0]      sum;
    diff = hi - lo;
    prod = diff * r;
    sum  = {1'b0, lo};
    if (INTERP && (RW > 0)) sum = sum + 18'(prod >> RW);
    return sat16(sum);
  endfunction

  function automatic logic [31:0] scale(input logic [15:0] m, input logic [4:0] e);
    return 32'((47'(m) << e) >> 15);
  endfunction

  // stage 1 -> 2: split L into exponent, table index and interpolation remainder
  assign k_p1    = l_p1_q[LOG_FRAC_BITS-1 -: LUT_BITS];
  assign addr_lo = {1'b0, k_p1};
  assign addr_hi = INTERP ? ({1'b0, k_p1} + 1'b1) : {1'b0, k_p1};

  if (RW > 0) begin : g_rem
    assign r_p1 = l_p1_q[RW_E-1:0];
  end else begin : g_no_rem
    assign r_p1 = '0;
  end

  log2lin_rom #(.LUT_BITS(LUT_BITS)) u_rom (
    .clk    (clk),
    .en     (en),
    .addr_a (addr_lo),
    .addr_b (addr_hi),
    .data_a (m_lo_p2),
    .data_b (m_hi_p2)
  );

  always_comb begin
    en        = o_tready | ~vld_p4_q;
    vld_p1_d  = vld_p1_q;  last_p1_d = last_p1_q;  l_p1_d    = l_p1_q;
    vld_p2_d  = vld_p2_q;  last_p2_d = last_p2_q;  e_p2_d    = e_p2_q;  r_p2_d = r_p2_q;
    vld_p3_d  = vld_p3_q;  last_p3_d = last_p3_q;  e_p3_d    = e_p3_q;  mant_p3_d = mant_p3_q;
    vld_p4_d  = vld_p4_q;  last_p4_d = last_p4_q;  data_p4_d = data_p4_q;
    if (en) begin
      vld_p1_d  = i_tvalid;
      last_p1_d = i_tlast;
      l_p1_d    = unpack_log(i_tdata[31:16], UNPACK);
      vld_p2_d  = vld_p1_q;
      last_p2_d = last_p1_q;
      e_p2_d    = l_p1_q[15:11];
      r_p2_d    = r_p1;
      // stage 2 -> 3: interpolate between adjacent table entries
      vld_p3_d  = vld_p2_q;
      last_p3_d = last_p2_q;
      e_p3_d    = e_p2_q;
      mant_p3_d = form_mant(m_lo_p2, m_hi_p2, r_p2_q);
      // stage 3 -> 4: shift Q1.15 mantissa by the integer exponent
      vld_p4_d  = vld_p3_q;
      last_p4_d = last_p3_q;
      data_p4_d = scale(mant_p3_q, e_p3_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      vld_p4_q  <= 1'b0;
      last_p4_q <= 1'b0;
      data_p4_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      vld_p3_q  <= vld_p3_d;
      vld_p4_q  <= vld_p4_d;
      last_p4_q <= last_p4_d;
      data_p4_q <= data_p4_d;
    end
  end

  always_ff @(posedge clk) begin
    l_p1_q    <= l_p1_d;
    last_p1_q <= last_p1_d;
    e_p2_q    <= e_p2_d;
    r_p2_q    <= r_p2_d;
    last_p2_q <= last_p2_d;
    e_p3_q    <= e_p3_d;
    last_p3_q <= last_p3_d;
    mant_p3_q <= mant_p3_d;
  end

  assign i_tready = en;
  assign o_tvalid = vld_p4_q;
  assign o_tdata  = data_p4_q;
  assign o_tlast  = last_p4_q;
endmodule

// File: tb/tb_axi_log2lin.sv
// Directed bench for axi_log2lin: three instances (unpacked/interp, packed/interp,
// unpacked/truncate) driven in lockstep, plus backpressure, reset and sweep sequences.
module tb_axi_log2lin;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, i_tvalid, i_tlast, o_tready;
  logic [31:0] tdata_u, tdata_p;
  logic [31:0] od_a, od_b, od_c;
  logic        ol_a, ol_b, ol_c, ov_a, ov_b, ov_c, ir_a, ir_b, ir_c;

  axi_log2lin #(.LUT_BITS(8), .INTERP(1'b1), .UNPACK(1'b0)) dut_a (
    .clk(clk), .reset(reset), .i_tdata(tdata_u), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
    .i_tready(ir_a), .o_tdata(od_a), .o_tlast(ol_a), .o_tvalid(ov_a), .o_tready(o_tready));
  axi_log2lin #(.LUT_BITS(8), .INTERP(1'b1), .UNPACK(1'b1)) dut_b (
    .clk(clk), .reset(reset), .i_tdata(tdata_p), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
    .i_tready(ir_b), .o_tdata(od_b), .o_tlast(ol_b), .o_tvalid(ov_b), .o_tready(o_tready));
  axi_log2lin #(.LUT_BITS(8), .INTERP(1'b0), .UNPACK(1'b0)) dut_c (
    .clk(clk), .reset(reset), .i_tdata(tdata_u), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
    .i_tready(ir_c), .o_tdata(od_c), .o_tlast(ol_c), .o_tvalid(ov_c), .o_tready(o_tready));

  typedef struct {
    logic [15:0] l;
    logic        last;
    logic [31:0] exp_i1;
    logic [31:0] exp_i0;
  } vec_t;

  vec_t vecs[8];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_l(input logic [15:0] l);
    tdata_u = {l, 16'h0000};
    tdata_p = {1'b0, l[15:1], 16'h0000};
  endtask

  function automatic longint mtab(input int j);
    return longint'($floor(32768.0 * $pow(2.0, real'(j) / 256.0) + 0.5));
  endfunction

  function automatic logic [31:0] ref_lin(input logic [15:0] l);
    int e, k, r;
    longint m0, m1, mant;
    e = int'(l[15:11]);
    k = int'(l[10:3]);
    r = int'(l[2:0]);
    m0 = mtab(k);
    m1 = mtab(k + 1);
    mant = m0 + ((m1 - m0) * r) / 8;
    if (mant > 65535) mant = 65535;
    return 32'((mant << e) >> 15);
  endfunction

  // One sample on an empty pipeline: must emerge exactly 4 edges after acceptance.
  task automatic apply_vec(input vec_t v, input string tag);
    logic [3:0] seen;
    @(negedge clk);
    drive_l(v.l);
    i_tlast  = v.last;
    i_tvalid = 1'b1;
    chk({tag, "_rdy"}, {31'h0, ir_a}, 32'h1);
    @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    seen = 4'h0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      seen[c-1] = ov_a;
    end
    chk({tag, "_latency"}, {28'h0, seen}, 32'h8);
    chk({tag, "_data_a"}, od_a, v.exp_i1);
    chk({tag, "_data_b"}, od_b, v.exp_i1);
    chk({tag, "_data_c"}, od_c, v.exp_i0);
    chk({tag, "_last_vld"}, {27'h0, ol_a, ol_b, ol_c, ov_b, ov_c}, {27'h0, {3{v.last}}, 2'b11});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bp_l [64];
    logic [31:0] prev;
    logic        ghost;
    int sent, got, cyc, sn, rn, mono_bad, err_bad;
    real ideal, outr;

    vecs[0] = '{16'h0000, 1'b0, 32'h0000_0001, 32'h0000_0001};
    vecs[1] = '{16'h0800, 1'b1, 32'h0000_0002, 32'h0000_0002};
    vecs[2] = '{16'h5000, 1'b0, 32'h0000_0400, 32'h0000_0400};
    vecs[3] = '{16'hF800, 1'b1, 32'h8000_0000, 32'h8000_0000};
    vecs[4] = '{16'h7C00, 1'b0, 32'h0000_B505, 32'h0000_B505};
    vecs[5] = '{16'hFFFE, 1'b1, 32'hFFD3_0000, 32'hFF4F_0000};
    vecs[6] = '{16'h0400, 1'b0, 32'h0000_0001, 32'h0000_0001};
    vecs[7] = '{16'h7FFE, 1'b1, 32'h0000_FFD3, 32'h0000_FF4F};

    reset = 1'b1; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;
    drive_l(16'h0);
    repeat (3) @(negedge clk);
    chk("rst_out", {ov_a, ol_a, od_a[29:0]}, 32'h0);
    chk("rst_empty_ready", {29'h0, ir_a, ir_b, ir_c}, 32'h7);
    reset = 1'b0;
    @(negedge clk);
    chk("empty_ready_stalled", {29'h0, ir_a, ov_a, ov_b}, 32'h4);
    o_tready = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // backpressure with a 64-sample packet
    for (int i = 0; i < 64; i++) bp_l[i] = 16'($urandom);
    sent = 0; got = 0; cyc = 0;
    while (got < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      o_tready = 1'($urandom_range(0, 1));
      i_tvalid = (sent < 64) && ($urandom_range(0, 3) != 0);
      if (sent < 64) begin
        drive_l(bp_l[sent]);
        i_tlast = (sent == 63);
      end
      #1;
      if ((sent - got) == 4 && !o_tready) chk("bp_full_ready", {31'h0, ir_a}, 32'h0);
      if (ov_a && o_tready) begin
        chk($sformatf("bp_data%0d", got), od_a, ref_lin(bp_l[got]));
        chk($sformatf("bp_last%0d", got), {31'h0, ol_a}, {31'h0, got == 63});
        got++;
      end
      if (i_tvalid && ir_a) sent++;
    end
    chk("bp_count", 32'(got), 32'd64);
    @(negedge clk);
    i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_drained", {31'h0, ov_a}, 32'h0);

    // reset with three samples in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_l(16'h5000 + 16'(i * 16'h0800));
      i_tvalid = 1'b1;
    end
    @(negedge clk);
    i_tvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_vld", {31'h0, ov_a}, 32'h0);
    chk("midrst_data", od_a, 32'h0);
    ghost = 1'b0;
    repeat (8) begin
      @(negedge clk);
      ghost = ghost | ov_a | ov_b | ov_c;
    end
    chk("midrst_no_ghost", {31'h0, ghost}, 32'h0);
    apply_vec(vecs[1], "post_rst");

    // full-rate sweep of every packed input through the packed instance
    sn = 0; rn = 0; cyc = 0; mono_bad = 0; err_bad = 0; prev = 32'h0;
    o_tready = 1'b1;
    while (rn < 32768 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (ov_b) begin
        ideal = $pow(2.0, real'(2 * rn) / 2048.0);
        outr  = real'(od_b);
        if (od_b < prev) mono_bad++;
        if (outr > ideal * (1.0 + 1.0 / 1024.0) || outr < $floor(ideal * (1.0 - 1.0 / 1024.0)))
          err_bad++;
        prev = od_b;
        rn++;
      end
      i_tvalid = (sn < 32768);
      i_tlast  = 1'b0;
      if (sn < 32768) drive_l(16'(2 * sn));
      #1;
      if (i_tvalid && ir_b) sn++;
    end
    i_tvalid = 1'b0;
    chk("sweep_count", 32'(rn), 32'd32768);
    chk("sweep_monotonic_violations", 32'(mono_bad), 32'd0);
    chk("sweep_error_violations", 32'(err_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
